// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : led_seq_ctrl_if
// Brief  : Four-phase req/ack mode-change channel for the LED sequencer.
// Rev    : 1.0
// ============================================================================
interface led_seq_ctrl_if;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;

  modport master (output mode_req, output mode_sel, input mode_ack);
  modport slave  (input mode_req, input mode_sel, output mode_ack);
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : led_seq_ctrl
// Brief  : Prescaled 4-bit LED pattern sequencer with req/ack mode control.
// Rev    : 1.0
// ============================================================================
module led_seq_ctrl #(
  parameter int STEP_CYC = 12_500_000,
  parameter int CNT_W    = 32
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              i_run,
  input  wire  [1:0]       i_speed,
  led_seq_ctrl_if.slave    hs,
  output logic [1:0]       o_mode,
  output logic [3:0]       o_led,
  output logic             o_step_pulse
);

  localparam logic [1:0] c_M_CHASE  = 2'd0;
  localparam logic [1:0] c_M_BOUNCE = 2'd1;
  localparam logic [1:0] c_M_BLINK  = 2'd2;
  localparam logic [1:0] c_M_COUNT  = 2'd3;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [3:0]       r_led;
  logic             r_dir_up;
  logic             r_ack;
  logic             r_pulse;

  logic [CNT_W-1:0] w_period;
  logic             w_term;
  logic             w_apply;
  logic [3:0]       w_next_led;
  logic             w_next_dir_up;
  logic [3:0]       w_start_led;

  assign w_period = CNT_W'(STEP_CYC) >> i_speed;
  // ">=" lets a speed increase that shrinks the period terminate at once.
  assign w_term   = i_run && (r_cnt >= (w_period - CNT_W'(1)));
  assign w_apply  = (r_state == S_IDLE) && hs.mode_req;

  always_comb begin
    case (hs.mode_sel)
      c_M_BLINK: w_start_led = 4'b1111;
      c_M_COUNT: w_start_led = 4'b0000;
      default:   w_start_led = 4'b0001;
    endcase
  end

  always_comb begin
    w_next_led    = 4'b0001;
    w_next_dir_up = r_dir_up;
    case (r_mode)
      c_M_CHASE: begin
        case (r_led)
          4'b0001: w_next_led = 4'b0010;
          4'b0010: w_next_led = 4'b0100;
          4'b0100: w_next_led = 4'b1000;
          default: w_next_led = 4'b0001;
        endcase
      end
      c_M_BOUNCE: begin
        case (r_led)
          4'b0001: w_next_led = 4'b0010;
          4'b1000: w_next_led = 4'b0100;
          4'b0010: w_next_led = r_dir_up ? 4'b0100 : 4'b0001;
          4'b0100: w_next_led = r_dir_up ? 4'b1000 : 4'b0010;
          default: w_next_led = 4'b0001;
        endcase
        // Direction follows the value being entered, so ends always turn around.
        if (w_next_led == 4'b1000)
          w_next_dir_up = 1'b0;
        else if (w_next_led == 4'b0001)
          w_next_dir_up = 1'b1;
      end
      c_M_BLINK: w_next_led = (r_led == 4'b1111) ? 4'b0000 : 4'b1111;
      default:   w_next_led = r_led + 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mode   <= c_M_CHASE;
      r_led    <= 4'b0000;
      r_dir_up <= 1'b1;
      r_ack    <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hs.mode_req) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!hs.mode_req) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      // A mode apply overrides any terminal count on the same edge.
      if (w_apply) begin
        r_mode   <= hs.mode_sel;
        r_led    <= w_start_led;
        r_dir_up <= 1'b1;
        r_cnt    <= '0;
      end else if (w_term) begin
        r_cnt    <= '0;
        r_led    <= w_next_led;
        r_dir_up <= w_next_dir_up;
        r_pulse  <= 1'b1;
      end else if (i_run) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign hs.mode_ack  = r_ack;
  assign o_mode       = r_mode;
  assign o_led        = r_led;
  assign o_step_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_led_seq_ctrl
// Brief  : Self-checking bench for led_seq_ctrl (vector table plus sequences).
// Rev    : 1.0
// ============================================================================
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [1:0] speed;
  logic [1:0] mode;
  logic [3:0] led;
  logic       step_pulse;

  int checks;
  int errors;

  led_seq_ctrl_if u_if ();

  led_seq_ctrl #(.STEP_CYC(8), .CNT_W(32)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (run),
    .i_speed      (speed),
    .hs           (u_if),
    .o_mode       (mode),
    .o_led        (led),
    .o_step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [1:0] speed;
    logic       req;
    logic [1:0] sel;
    logic [3:0] exp_led;
    logic [1:0] exp_mode;
    logic       exp_ack;
    logic       exp_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rq, input logic [1:0] sl, input logic [3:0] el,
                              input logic [1:0] em, input logic ea, input logic ep);
    vec_t v;
    v.run = 1'b1; v.speed = 2'd3; v.req = rq; v.sel = sl;
    v.exp_led = el; v.exp_mode = em; v.exp_ack = ea; v.exp_pulse = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_pulse && n < 64);
  endtask

  task automatic cycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
  endtask

  int         n;
  int         np;
  logic [3:0] held;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    run = 1'b1;
    speed = 2'd0;
    u_if.mode_req = 1'b0;
    u_if.mode_sel = 2'd0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outs", {led, mode, u_if.mode_ack, step_pulse}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Chase at P=8
    begin
      logic [3:0] chase[5];
      chase[0] = 4'b0001; chase[1] = 4'b0010; chase[2] = 4'b0100;
      chase[3] = 4'b1000; chase[4] = 4'b0001;
      for (int k = 0; k < 5; k++) begin
        wait_step(n);
        chk($sformatf("chase_gap%0d", k), n, 8);
        chk($sformatf("chase_led%0d", k), led, chase[k]);
      end
    end

    // Vector table, all at P=1 so every cycle is a step
    add(0, 0, 4'b0010, 0, 0, 1);
    add(0, 0, 4'b0100, 0, 0, 1);
    add(0, 0, 4'b1000, 0, 0, 1);
    add(0, 0, 4'b0001, 0, 0, 1);
    add(1, 1, 4'b0001, 1, 1, 0);
    add(1, 1, 4'b0010, 1, 1, 1);
    add(1, 3, 4'b0100, 1, 1, 1);
    add(1, 3, 4'b1000, 1, 1, 1);
    add(0, 1, 4'b0100, 1, 0, 1);
    add(0, 1, 4'b0010, 1, 0, 1);
    add(0, 1, 4'b0001, 1, 0, 1);
    add(0, 1, 4'b0010, 1, 0, 1);
    add(0, 1, 4'b0100, 1, 0, 1);
    add(1, 2, 4'b1111, 2, 1, 0);
    add(0, 2, 4'b0000, 2, 0, 1);
    add(0, 2, 4'b1111, 2, 0, 1);
    add(0, 2, 4'b0000, 2, 0, 1);
    add(1, 3, 4'b0000, 3, 1, 0);
    for (int k = 1; k <= 17; k++)
      add(0, 3, 4'(k % 16), 3, 0, 1);
    add(1, 3, 4'b0000, 3, 1, 0);
    add(0, 3, 4'b0001, 3, 0, 1);

    foreach (vecs[i]) begin
      run = vecs[i].run;
      speed = vecs[i].speed;
      u_if.mode_req = vecs[i].req;
      u_if.mode_sel = vecs[i].sel;
      @(negedge clk);
      chk($sformatf("vec%0d {led,mode,ack,pulse}", i),
          {led, mode, u_if.mode_ack, step_pulse},
          {vecs[i].exp_led, vecs[i].exp_mode, vecs[i].exp_ack, vecs[i].exp_pulse});
    end

    // Speed change 0 -> 2 with cnt=5 terminates on the next edge
    speed = 2'd0;
    cycles(5, np);
    chk("spd_no_pulse_p8", np, 0);
    speed = 2'd2;
    @(negedge clk);
    chk("spd_shrink_pulse", step_pulse, 1);
    chk("spd_shrink_led", led, 4'b0010);
    wait_step(n);
    chk("spd_p2_gap", n, 2);
    chk("spd_p2_led", led, 4'b0011);

    // Request colliding with a terminal count
    speed = 2'd0;
    cycles(7, np);
    chk("coll_pre_no_pulse", np, 0);
    u_if.mode_req = 1'b1;
    u_if.mode_sel = 2'd0;
    @(negedge clk);
    chk("coll_apply", {led, mode, u_if.mode_ack, step_pulse}, {4'b0001, 2'd0, 1'b1, 1'b0});
    u_if.mode_req = 1'b0;
    wait_step(n);
    chk("coll_next_gap", n, 8);
    chk("coll_next_led", led, 4'b0010);

    // Freeze with run=0 holds counter and LEDs
    cycles(3, np);
    run = 1'b0;
    held = led;
    cycles(20, np);
    chk("freeze_no_pulse", np, 0);
    chk("freeze_led", led, held);
    run = 1'b1;
    wait_step(n);
    chk("freeze_resume_gap", n, 5);
    chk("freeze_resume_led", led, 4'b0100);

    // Request while frozen still applies
    run = 1'b0;
    u_if.mode_req = 1'b1;
    u_if.mode_sel = 2'd2;
    @(negedge clk);
    chk("frz_req_apply", {led, mode, u_if.mode_ack}, {4'b1111, 2'd2, 1'b1});
    u_if.mode_req = 1'b0;
    cycles(10, np);
    chk("frz_req_no_pulse", np, 0);
    chk("frz_req_led", {led, u_if.mode_ack}, {4'b1111, 1'b0});

    // Asynchronous reset in the middle of an ACK
    run = 1'b1;
    u_if.mode_req = 1'b1;
    u_if.mode_sel = 2'd3;
    @(negedge clk);
    chk("ar_ack_before", u_if.mode_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outs_async", {led, mode, u_if.mode_ack, step_pulse}, 32'h0);
    u_if.mode_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    u_if.mode_req = 1'b1;
    u_if.mode_sel = 2'd1;
    @(negedge clk);
    chk("ar_fresh_req", {led, mode, u_if.mode_ack}, {4'b0001, 2'd1, 1'b1});
    u_if.mode_req = 1'b0;
    @(negedge clk);
    chk("ar_ack_drop", u_if.mode_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer and controller for the 4-bit board LED bank.
- Generates the step timebase from clk and runs one of four display patterns: chase, bounce, blink, binary count.
- Accepts mode changes from a requester (key handler or host logic) over a four-phase req/ack handshake.
- Sits between the user-input logic and the LED pins. It replaces free-running, hard-coded LED timers.

Parameters:
- STEP_CYC, 12_500_000: clk cycles per pattern step at speed=0 (0.25 s at 50 MHz). Minimum legal value 8.
- CNT_W, 32: prescaler counter width. Must hold STEP_CYC-1.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous, active-low reset.
- run, input, 1: 1 = pattern advances; 0 = freeze counter and LEDs.
- speed, input, 2: step period = STEP_CYC >> speed (x1, x2, x4, x8 rate).
- mode_req, input, 1: mode-change request, level, four-phase.
- mode_sel, input, 2: requested mode. Must be stable while mode_req=1. 0=CHASE, 1=BOUNCE, 2=BLINK, 3=COUNT.
- mode_ack, output, 1: handshake acknowledge.
- mode, output, 2: currently active mode.
- led, output, 4: LED drive, high active.
- step_pulse, output, 1: one-cycle pulse on each pattern advance.

Behaviour:
- Reset state:
  - All outputs are registered.
  - Reset values: led=0000, mode=0 (CHASE), mode_ack=0, step_pulse=0, prescaler cnt=0, bounce dir=up, handshake FSM=IDLE.
  - Reset is effective mid-handshake or mid-step: ack drops immediately and the FSM returns to IDLE.
- Prescaler:
  - period P = STEP_CYC >> speed.
  - Terminal condition: run=1 and cnt >= P-1. The ">=" covers a speed change that shrinks P below the current cnt.
  - On terminal: cnt<=0, step occurs.
  - Otherwise, with run=1: cnt<=cnt+1. With run=0: cnt holds and no step occurs.
  - Step spacing is exactly P cycles. With P=1 a step occurs every cycle.
- Step:
  - On the step edge, led loads the next pattern value and step_pulse=1 for that one cycle.
  - step_pulse is 0 in all other cycles.
- Patterns (next value on each step):
  - CHASE: 0001→0010→0100→1000→0001. Any value that is not one-hot (e.g. 0000 after reset) steps to 0001.
  - BOUNCE: 0001→0010→0100→1000→0100→0010→0001→…, period 6 steps.
    - dir flips to down on reaching 1000 and to up on reaching 0001.
    - A value that is not one-hot steps to 0001 with dir=up.
  - BLINK: 0000↔1111. Any other value steps to 1111.
  - COUNT: led+1, mod 16. 1111 wraps to 0000.
- Handshake FSM (IDLE, ACK):
  - IDLE, mode_req=1 sampled at edge N. At edge N:
    - mode<=mode_sel.
    - led<=start value: CHASE 0001, BOUNCE 0001 with dir=up, BLINK 1111, COUNT 0000.
    - cnt<=0, mode_ack<=1, FSM→ACK.
  - ACK: mode_ack stays 1 while mode_req=1. mode_req is ignored as a new request in this state.
  - ACK, mode_req=0 sampled: mode_ack<=0, FSM→IDLE. A new request is accepted at the earliest on the following edge.
  - A request for the already-active mode still restarts the pattern.
  - Apply works regardless of run. With run=0, led shows the start value and then stays frozen.
- Simultaneous events:
  - Mode apply and a terminal count on the same edge: apply wins. led=start value, cnt=0, step_pulse=0.
  - Next step occurs P cycles after apply (with run=1).
- mode_sel changes while in ACK have no effect.

Test Plan:
- Reset / chase (STEP_CYC=8, speed=0, run=1, no request): release reset → led 0000. First step_pulse at cycle 8, then every 8 cycles. led sequence 0001,0010,0100,1000,0001.
- Speed (speed=3, P=1): step every cycle, chase cycles every 4 clks. Switch speed 0→2 with cnt=5 → terminal on the next edge (cnt>=1), then steps every 2 cycles.
- Bounce: req mode 1 → next edge mode_ack=1, led=0001, mode=1. Hold req 3 cycles → ack held 3 cycles. Drop req → ack 0 next edge. 8 steps → 0010,0100,1000,0100,0010,0001,0010,0100.
- Blink/count: mode 2 → 1111,0000,1111. Mode 3 over 17 steps → 0000→…→1111→0000→0001 (wrap checked).
- Collision/freeze: assert req on the same edge as a terminal count → led=start value, step_pulse=0, next step exactly P later. run=0 for 20 cycles → led, cnt unchanged and no step_pulse. A request during run=0 still acks and loads the start value.
- Async reset mid-ACK: rst_n low with mode_ack=1 → mode_ack, led, mode, step_pulse go 0 without a clock edge. After release, the FSM accepts a fresh request.
